tinyalu_param: RTL and testbench

Parametrised, synthesisable successor to the fixed 8-bit TinyALU: a start/done-handshaked ALU with configurable operand width and multiplier latency. It adds a subtract operation and a visible busy indication. It is the DUT driven by the tinyalu_bfm interface in the block-level UVM bench, and it is reused wherever a small multi-cycle arithmetic unit is needed.

---
 rtl/tinyalu_pkg.sv | 31 +++
 rtl/tinyalu_mul_pipe.sv | 55 +++++
 rtl/tinyalu_param.sv | 165 ++++++++++++++++
 tb/tb_tinyalu_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// ============================================================================
// tinyalu_pkg : shared operation codes, FSM states and op classification
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        sub_op = 3'b101,
        rsv_op = 3'b110,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    function automatic logic is_single_cycle(input operation_t op);
        return op inside {add_op, and_op, xor_op, sub_op, rst_op};
    endfunction

endpackage

`default_nettype wire

// File: rtl/tinyalu_mul_pipe.sv
// ============================================================================
// tinyalu_mul_pipe : WIDTH x WIDTH unsigned multiplier, STAGES register stages,
//                    valid pipeline and asynchronous active-low clear
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tinyalu_mul_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 valid_o,
    output logic [2*WIDTH-1:0]   prod_o
);

    logic [2*WIDTH-1:0] prod_w;
    assign prod_w = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    generate
        if (STAGES == 0) begin : g_comb
            logic unused_clk_w;
            assign unused_clk_w = clk ^ clr_n;
            assign valid_o      = valid_i;
            assign prod_o       = prod_w;
        end else begin : g_pipe
            logic [2*WIDTH-1:0] prod_q [STAGES];
            logic [STAGES-1:0]  vld_q;

            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < STAGES; i++) prod_q[i] <= '0;
                end else begin
                    vld_q[0]  <= valid_i;
                    prod_q[0] <= prod_w;
                    for (int i = 1; i < STAGES; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        prod_q[i] <= prod_q[i-1];
                    end
                end
            end

            assign valid_o = vld_q[STAGES-1];
            assign prod_o  = prod_q[STAGES-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tinyalu_param.sv
// ============================================================================
// tinyalu_param : start/done handshaked ALU, parametrised width and mul latency
// Optional feature macro: TINYALU_FLAGS_EN (adds registered zero/carry flags)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tinyalu_param
    import tinyalu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MUL_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  operation_t           op,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
`ifdef TINYALU_FLAGS_EN
    ,
    output logic                 zero,
    output logic                 carry
`endif
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = (MUL_STAGES > 2) ? $clog2(MUL_STAGES - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (MUL_STAGES > 2) ? CNT_W'(MUL_STAGES - 2) : '0;

    generate
        if (WIDTH < 2) begin : g_chk_width
            $error("tinyalu_param: WIDTH must be at least 2");
        end
        if (MUL_STAGES < 1) begin : g_chk_stages
            $error("tinyalu_param: MUL_STAGES must be at least 1");
        end
    endgenerate

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [RW-1:0]     result_q;

    logic              acc_single_w;
    logic              acc_mul_w;
    logic [RW-1:0]     a_ext_w;
    logic [RW-1:0]     b_ext_w;
    logic [RW-1:0]     single_res_w;
    logic              mul_vld_w;
    logic [RW-1:0]     mul_prod_w;
    logic              done_d;
    logic [RW-1:0]     result_d;

    assign acc_single_w = start && !busy_q && is_single_cycle(op);
    assign acc_mul_w    = start && !busy_q && (op == mul_op);
    assign a_ext_w      = {{WIDTH{1'b0}}, A};
    assign b_ext_w      = {{WIDTH{1'b0}}, B};

    always_comb begin
        single_res_w = '0;
        case (op)
            add_op:  single_res_w = a_ext_w + b_ext_w;
            and_op:  single_res_w = a_ext_w & b_ext_w;
            xor_op:  single_res_w = a_ext_w ^ b_ext_w;
            sub_op:  single_res_w = a_ext_w - b_ext_w;
            default: single_res_w = '0;
        endcase
    end

    // The result register is the last of the MUL_STAGES stages, so the pipe holds one fewer.
    tinyalu_mul_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (MUL_STAGES - 1)
    ) u_mul_pipe (
        .clk     (clk),
        .clr_n   (reset_n),
        .valid_i (acc_mul_w),
        .a_i     (A),
        .b_i     (B),
        .valid_o (mul_vld_w),
        .prod_o  (mul_prod_w)
    );

    assign done_d   = acc_single_w | mul_vld_w;
    assign result_d = mul_vld_w ? mul_prod_w : single_res_w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= done_d;
            if (done_d) result_q <= result_d;
            case (state_q)
                IDLE: begin
                    if (acc_mul_w && (MUL_STAGES > 1)) begin
                        state_q <= MUL;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_INIT;
                    end
                end
                MUL: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

`ifdef TINYALU_FLAGS_EN
    logic zero_q;
    logic carry_q;
    logic carry_d;

    // Single-cycle carries use the operands live at acceptance; mul uses its product.
    always_comb begin
        carry_d = 1'b0;
        if (mul_vld_w) begin
            carry_d = |mul_prod_w[RW-1:WIDTH];
        end else if (acc_single_w) begin
            case (op)
                add_op:  carry_d = single_res_w[WIDTH];
                sub_op:  carry_d = (A < B);
                default: carry_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (done_d) begin
            zero_q  <= (result_d == '0);
            carry_q <= carry_d;
        end
    end

    assign zero  = zero_q;
    assign carry = carry_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tinyalu_param.sv
// ============================================================================
// tb_tinyalu_param : randomized + directed bench for tinyalu_param
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tinyalu_param;
    import tinyalu_pkg::*;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int W2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic [W-1:0]       a, b;
    operation_t         op;
    logic               start;
    logic               busy, done;
    logic [2*W-1:0]     result;

    logic [W2-1:0]      a2, b2;
    operation_t         op2;
    logic               start2;
    logic               busy2, done2;
    logic [2*W2-1:0]    result2;

`ifdef TINYALU_FLAGS_EN
    logic zero, carry, zero2, carry2;
`endif

    tinyalu_param #(.WIDTH(W), .MUL_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .A(a), .B(b), .op(op), .start(start),
        .busy(busy), .done(done), .result(result)
`ifdef TINYALU_FLAGS_EN
        , .zero(zero), .carry(carry)
`endif
    );

    tinyalu_param #(.WIDTH(W2), .MUL_STAGES(1)) dut16 (
        .clk(clk), .reset_n(reset_n), .A(a2), .B(b2), .op(op2), .start(start2),
        .busy(busy2), .done(done2), .result(result2)
`ifdef TINYALU_FLAGS_EN
        , .zero(zero2), .carry(carry2)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a list of pending completions keyed by clock-edge number.
    typedef struct {
        int          due;
        logic [63:0] val;
        logic        cy;
    } pend_t;

    pend_t       pend[$];
    int          edge_no   = 0;
    int          free_edge = 0;
    logic [63:0] exp_res   = '0;
    logic        exp_done  = 1'b0;
    logic        exp_busy  = 1'b0;
    logic        exp_zero  = 1'b0;
    logic        exp_cy    = 1'b0;

    function automatic logic [63:0] ref_val(input operation_t o, input longint unsigned x,
                                            input longint unsigned y);
        longint unsigned mask = (64'd1 << (2 * W)) - 1;
        case (o)
            add_op:  return x + y;
            and_op:  return x & y;
            xor_op:  return x ^ y;
            mul_op:  return x * y;
            sub_op:  return (x - y) & mask;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_cy(input operation_t o, input longint unsigned x,
                                    input longint unsigned y);
        case (o)
            add_op:  return ((x + y) >> W) != 0;
            sub_op:  return x < y;
            mul_op:  return ((x * y) >> W) != 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        int lat;
        if (start && edge_no >= free_edge && op inside {add_op, and_op, xor_op, mul_op, sub_op, rst_op}) begin
            lat = (op == mul_op) ? S : 1;
            pend.push_back('{due: edge_no + lat - 1, val: ref_val(op, a, b), cy: ref_cy(op, a, b)});
            free_edge = edge_no + lat;
        end
        exp_done = 1'b0;
        if (pend.size() > 0 && pend[0].due == edge_no) begin
            exp_done = 1'b1;
            exp_res  = pend[0].val;
            exp_zero = (pend[0].val == 0);
            exp_cy   = pend[0].cy;
            void'(pend.pop_front());
        end
        exp_busy = (edge_no + 1 < free_edge);
    endtask

    task automatic tick();
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        check("done", done, exp_done);
        check("busy", busy, exp_busy);
        check("result", result, exp_res);
`ifdef TINYALU_FLAGS_EN
        check("zero", zero, exp_zero);
        check("carry", carry, exp_cy);
`endif
    endtask

    task automatic step(input logic s, input operation_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = s; op = o; a = x; b = y;
        tick();
    endtask

    task automatic reset_pulse(input logic start_at_release);
        reset_n = 1'b0;
        start   = 1'b0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, '0);
`ifdef TINYALU_FLAGS_EN
        check("rst_zero", zero, 1'b0);
        check("rst_carry", carry, 1'b0);
`endif
        pend.delete();
        exp_res = '0; exp_done = 1'b0; exp_busy = 1'b0; exp_zero = 1'b0; exp_cy = 1'b0;
        free_edge = 0;
        @(negedge clk);
        if (start_at_release) begin
            start = 1'b1; op = add_op; a = 8'd10; b = 8'd20;
        end
        reset_n = 1'b1;
    endtask

    initial begin
        start = 1'b0; op = no_op; a = '0; b = '0;
        start2 = 1'b0; op2 = no_op; a2 = '0; b2 = '0;
        reset_pulse(1'b0);
        check("rst16_busy", busy2, 1'b0);
        check("rst16_done", done2, 1'b0);
        check("rst16_result", result2, '0);

        // add with carry into bit WIDTH
        step(1'b1, add_op, 8'd255, 8'd1);
        check("add_255_1", result, 64'h0100);
        step(1'b0, no_op, 8'd0, 8'd0);

        // full-scale multiply latency and busy window
        step(1'b1, mul_op, 8'd255, 8'd255);
        check("mul_busy_n1", busy, 1'b1);
        step(1'b0, no_op, 8'd0, 8'd0);
        check("mul_busy_n2", busy, 1'b1);
        step(1'b0, no_op, 8'd0, 8'd0);
        check("mul_done", done, 1'b1);
        check("mul_255_255", result, 64'hFE01);

        step(1'b1, sub_op, 8'd3, 8'd5);
        check("sub_3_5", result, 64'hFFFE);
        step(1'b1, xor_op, 8'hAA, 8'hAA);
        check("xor_zero", result, 64'h0);

        // held add during mul is accepted at the edge that ends the done cycle
        step(1'b1, mul_op, 8'd7, 8'd9);
        step(1'b1, add_op, 8'd1, 8'd1);
        step(1'b1, add_op, 8'd1, 8'd1);
        check("mul_7_9", result, 64'd63);
        step(1'b1, add_op, 8'd1, 8'd1);
        check("held_add", result, 64'h0002);
        step(1'b0, no_op, 8'd0, 8'd0);

        // reset one cycle into a multiply, then release with start already high
        step(1'b1, mul_op, 8'd200, 8'd100);
        reset_pulse(1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, mul_op, 8'd1, 8'd1);
        reset_pulse(1'b1);
        tick();
        check("add_after_release", result, 64'd30);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse($urandom_range(0, 1) == 1);
                tick();
            end else begin
                step($urandom_range(0, 3) != 0, operation_t'($urandom_range(0, 7)),
                     8'($urandom), 8'($urandom));
            end
        end
        step(1'b0, no_op, 8'd0, 8'd0);

        // WIDTH=16, MUL_STAGES=1 back-to-back with start held
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start2 = 1'b1;
            op2    = (i % 2 == 0) ? mul_op : rst_op;
            a2     = 16'hFFFF;
            b2     = 16'd2;
            @(posedge clk);
            #1;
            check("w16_done", done2, 1'b1);
            check("w16_busy", busy2, 1'b0);
            check("w16_result", result2, (i % 2 == 0) ? 64'h1FFFE : 64'h0);
`ifdef TINYALU_FLAGS_EN
            check("w16_zero", zero2, (i % 2 == 0) ? 1'b0 : 1'b1);
            check("w16_carry", carry2, (i % 2 == 0) ? 1'b1 : 1'b0);
`endif
        end
        @(negedge clk);
        start2 = 1'b0;
        @(posedge clk);
        #1;
        check("w16_idle_done", done2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
